// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared stage record and elaboration helpers for pipe_adder
package pipe_adder_pkg;
   localparam int MIN_WIDTH = 1;
   localparam int MIN_STAGES = 1;
   typedef struct packed {
      logic valid;
      logic carry;
   } stage_ctl_t;
   function automatic int chunk_width(input int width, input int stages);
      return stages > 0 ? width / stages : 1;
   endfunction
   function automatic bit cfg_ok(input int width, input int stages);
      return width >= MIN_WIDTH && stages >= MIN_STAGES && stages <= width && width % stages == 0;
   endfunction
endpackage

// File: rtl/pipe_adder_stage.sv
// pipe_adder_stage: one CW-bit ripple chunk plus its stage register
// PIPE_ADDER_OVF_EN adds a registered signed-overflow output
module pipe_adder_stage
   import pipe_adder_pkg::*;
#(
   parameter int W = 8,
   parameter int CW = 4,
   parameter int K = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         up_valid,
   input  logic         up_carry,
   input  logic [W-1:0] up_d,
   input  logic [W-1:0] up_b,
   output logic         valid,
   output logic         carry,
   output logic [W-1:0] d,
   output logic [W-1:0] b
`ifdef PIPE_ADDER_OVF_EN
   ,
   output logic         ovf
`endif
);
   localparam int LO = K * CW;
   // operand b chunks at or below this stage are consumed and dropped
   localparam logic [W-1:0] KEEP = {W{1'b1}} << ((K + 1) * CW);
   stage_ctl_t r;
   logic [W-1:0] dr, br, nd;
   logic [CW-1:0] x, y, s;
   logic cy;
   assign x = up_d[LO +: CW];
   assign y = up_b[LO +: CW];
   always_comb begin
      cy = up_carry;
      s = '0;
      for (int i = 0; i < CW; i++) begin
         s[i] = x[i] ^ y[i] ^ cy;
         cy = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
      end
   end
   // d carries finished sum bits below and untouched a bits above
   always_comb begin
      nd = up_d;
      nd[LO +: CW] = s;
   end
`ifdef PIPE_ADDER_OVF_EN
   logic ovr;
   assign ovf = ovr;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r <= '0;
         dr <= '0;
         br <= '0;
`ifdef PIPE_ADDER_OVF_EN
         ovr <= 1'b0;
`endif
      end else if (load) begin
         r <= '{valid: up_valid, carry: cy};
         dr <= nd;
         br <= up_b & KEEP;
`ifdef PIPE_ADDER_OVF_EN
         ovr <= (x[CW-1] == y[CW-1]) && (s[CW-1] != x[CW-1]);
`endif
      end
   end
   assign valid = r.valid;
   assign carry = r.carry;
   assign d = dr;
   assign b = br;
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined ripple-carry adder with valid/ready handshake
// PIPE_ADDER_OVF_EN adds the ovf signed-overflow port
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef PIPE_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = chunk_width(WIDTH, STAGES);
   if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipe_adder: WIDTH must be >=1, 1<=STAGES<=WIDTH, WIDTH%%STAGES==0");
   end
   logic [STAGES:0] vq, cq, adv;
   logic [WIDTH-1:0] dq [STAGES+1];
   logic [WIDTH-1:0] bq [STAGES+1];
   assign vq[0] = in_valid;
   assign cq[0] = cin;
   assign dq[0] = a;
   assign bq[0] = b;
   // a stage advances when empty or when its successor advances
   always_comb begin
      adv = '0;
      adv[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) adv[k] = !vq[k+1] || adv[k+1];
   end
`ifdef PIPE_ADDER_OVF_EN
   logic ovq [STAGES];
   assign ovf = ovq[STAGES-1];
`endif
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipe_adder_stage #(.W(WIDTH), .CW(CW), .K(k)) u_stage (
         .clk(clk),
         .rst_n(rst_n),
         .load(adv[k]),
         .up_valid(vq[k]),
         .up_carry(cq[k]),
         .up_d(dq[k]),
         .up_b(bq[k]),
         .valid(vq[k+1]),
         .carry(cq[k+1]),
         .d(dq[k+1]),
         .b(bq[k+1])
`ifdef PIPE_ADDER_OVF_EN
         ,
         .ovf(ovq[k])
`endif
      );
   end
   assign in_ready = adv[0];
   assign out_valid = vq[STAGES];
   assign sum = dq[STAGES];
   assign cout = cq[STAGES];
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed self-checking bench for pipe_adder
// PIPE_ADDER_OVF_EN selects STAGES=4 and adds the ovf checks
module tb_pipe_adder;
`ifdef PIPE_ADDER_OVF_EN
   localparam int ST = 4;
`else
   localparam int ST = 2;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic in_valid = 1'b0, in_ready, cin = 1'b0;
   logic out_valid, out_ready = 1'b1, cout;
   logic [7:0] a = '0, b = '0, sum;
`ifdef PIPE_ADDER_OVF_EN
   logic ovf;
`endif
   int n_cmp = 0, n_err = 0;
   always #5 clk = ~clk;
   pipe_adder #(.WIDTH(8), .STAGES(ST)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a),
      .b(b),
      .cin(cin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum(sum),
      .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
      ,
      .ovf(ovf)
`endif
   );
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic [7:0] xa, input logic [7:0] xb, input logic xc);
      in_valid = 1'b1;
      a = xa;
      b = xb;
      cin = xc;
   endtask
   task automatic xfer(input string tag, input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                       input logic [7:0] es, input logic ec, input logic eo);
      drive(xa, xb, xc);
      #1;
      chk({tag, "_in_ready"}, in_ready, 1);
      tick;
      in_valid = 1'b0;
      for (int i = 0; i < ST - 1; i++) begin
         chk({tag, "_early"}, out_valid, 0);
         tick;
      end
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_cout"}, cout, ec);
`ifdef PIPE_ADDER_OVF_EN
      chk({tag, "_ovf"}, ovf, eo);
`else
      if (eo === 1'bx) chk({tag, "_ovf_arg"}, 0, 1);
`endif
      tick;
      chk({tag, "_drained"}, out_valid, 0);
   endtask
   logic [7:0] sa [4] = '{8'h01, 8'h10, 8'h80, 8'hAA};
   logic [7:0] sb [4] = '{8'h02, 8'h20, 8'h80, 8'h55};
   logic       sc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic [7:0] ss [4] = '{8'h03, 8'h30, 8'h00, 8'h00};
   logic       so [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   logic [7:0] ba [4] = '{8'h11, 8'hF0, 8'h7F, 8'h01};
   logic [7:0] bb [4] = '{8'h22, 8'h10, 8'h80, 8'h01};
   logic       bc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
   logic [7:0] bs [4] = '{8'h33, 8'h00, 8'h00, 8'h02};
   logic       bo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
   initial begin
      int ni, no;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_valid", out_valid, 0);
      chk("rst_sum", sum, 8'h00);
      chk("rst_cout", cout, 0);
`ifdef PIPE_ADDER_OVF_EN
      chk("rst_ovf", ovf, 0);
`endif
      tick;
      rst_n = 1'b1;
      tick;
      chk("rst_in_ready", in_ready, 1);
      xfer("carry_ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      xfer("carry_0f00", 8'h0F, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0);
      // back-to-back stream, one result per cycle
      out_ready = 1'b1;
      drive(sa[0], sb[0], sc[0]);
      for (int n = 1; n <= 3 + ST; n++) begin
         tick;
         if (n >= ST) begin
            chk("stream_valid", out_valid, 1);
            chk("stream_sum", sum, ss[n-ST]);
            chk("stream_cout", cout, so[n-ST]);
         end else chk("stream_early", out_valid, 0);
         if (n < 4) drive(sa[n], sb[n], sc[n]);
         else in_valid = 1'b0;
      end
      tick;
      chk("stream_drained", out_valid, 0);
      // backpressure: consumer stalls for four cycles
      ni = 0;
      no = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (cyc == 4) chk("bp_accepted", ni, ST);
         out_ready = cyc >= 4;
         if (ni < 4) drive(ba[ni], bb[ni], bc[ni]);
         else in_valid = 1'b0;
         #1;
         if (!out_ready && cyc >= ST) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_sum", sum, bs[0]);
            chk("bp_hold_cout", cout, bo[0]);
         end
         if (out_valid && out_ready) begin
            if (no < 4) begin
               chk("bp_sum", sum, bs[no]);
               chk("bp_cout", cout, bo[no]);
            end
            no++;
         end
         if (in_valid && in_ready) ni++;
         tick;
      end
      chk("bp_count", no, 4);
      chk("bp_idle", out_valid, 0);
      // reset with two transactions in flight
      out_ready = 1'b0;
      drive(8'h12, 8'h34, 1'b0);
      tick;
      drive(8'h56, 8'h78, 1'b0);
      tick;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_sum", sum, 8'h00);
      chk("mid_rst_cout", cout, 0);
      tick;
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick;
      chk("mid_rst_in_ready", in_ready, 1);
      for (int i = 0; i < ST + 2; i++) begin
         chk("mid_rst_no_out", out_valid, 0);
         tick;
      end
      xfer("after_rst", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
`ifdef PIPE_ADDER_OVF_EN
      xfer("ovf_7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      xfer("ovf_8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      xfer("ovf_4020", 8'h40, 8'h20, 1'b0, 8'h60, 1'b0, 1'b0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
